// File: rtl/pa_pkg.sv
// pa_pkg: shared scheduler state, vector type and drain-length helper for the PE array
package pa_pkg;
  localparam int PA_SIZE_MAT = 16;
  localparam int PA_WIDTH_DATA = 16;
  localparam int PA_WIDTH_MDATA = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pa_sched_state_e;
  typedef logic [PA_SIZE_MAT*PA_WIDTH_DATA-1:0] pa_vec_t;
  function automatic int drain_beats(input int size_mat, input int width_data, input int width_mdata);
    return size_mat * size_mat * width_data / width_mdata;
  endfunction
  localparam int DRAIN_BEATS = drain_beats(PA_SIZE_MAT, PA_WIDTH_DATA, PA_WIDTH_MDATA);
endpackage

// File: rtl/pa_opnd_fifo.sv
// pa_opnd_fifo: two-entry operand FIFO allowing push and pop in the same cycle
module pa_opnd_fifo #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wptr, rptr;
  assign dout = mem[rptr];
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      count <= '0;
    end else begin
      if (push) mem[wptr] <= din;
      wptr <= wptr ^ push;
      rptr <= rptr ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/pa_tile_sched.sv
// pa_tile_sched: per-tile scheduler issuing K operand pairs to the PE array and awaiting its drain
module pa_tile_sched import pa_pkg::*; #(
  parameter int SIZE_MAT = 16,
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_MDATA = 32,
  parameter int WIDTH_K = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid_i,
  input  logic [WIDTH_K-1:0]             cfg_k_i,
  output logic                           cfg_ready_o,
  input  logic                           op_valid_i,
  input  logic [SIZE_MAT*WIDTH_DATA-1:0] op_v_i,
  input  logic [SIZE_MAT*WIDTH_DATA-1:0] op_h_i,
  output logic                           op_ready_o,
  output logic [SIZE_MAT*WIDTH_DATA-1:0] pa_v_bus_o,
  output logic [SIZE_MAT*WIDTH_DATA-1:0] pa_h_bus_o,
  output logic                           pa_data_rdy_o,
  input  logic                           pa_read_en_i,
  input  logic                           pa_out_valid_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);
  localparam int VW = SIZE_MAT * WIDTH_DATA;
  localparam int DB = drain_beats(SIZE_MAT, WIDTH_DATA, WIDTH_MDATA);
  localparam int DW = $clog2(DB) + 1;
  pa_sched_state_e state, nxt;
  logic [WIDTH_K-1:0] k_q, acc_cnt, iss_cnt;
  logic [DW-1:0] drn_cnt;
  logic [1:0] count;
  logic [2*VW-1:0] head;
  logic push, pop, start, last_pop, beat, last_beat, err_d;
  assign start = state == IDLE && cfg_valid_i && cfg_k_i != '0;
  assign op_ready_o = state == RUN && count != 2'd2 && acc_cnt < k_q;
  assign pa_data_rdy_o = state == RUN && count != 2'd0;
  assign push = op_valid_i && op_ready_o;
  assign pop = pa_read_en_i && pa_data_rdy_o;
  assign last_pop = pop && iss_cnt == k_q - 1'b1;
  assign beat = state == DRAIN && pa_out_valid_i;
  assign last_beat = beat && drn_cnt == DW'(DB - 1);
  assign err_d = (state == IDLE && cfg_valid_i && cfg_k_i == '0) || (pa_out_valid_i && state != DRAIN);
  assign cfg_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign {pa_v_bus_o, pa_h_bus_o} = head;
  pa_opnd_fifo #(.W(2*VW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({op_v_i, op_h_i}),
    .dout(head),
    .count(count)
  );
  always_comb
    nxt = state == IDLE  ? (start ? RUN : IDLE) :
          state == RUN   ? (last_pop ? DRAIN : RUN) :
          state == DRAIN ? (last_beat ? DONE : DRAIN) : IDLE;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      k_q <= '0;
      acc_cnt <= '0;
      iss_cnt <= '0;
      drn_cnt <= '0;
      err_o <= 1'b0;
    end else begin
      err_o <= err_d;
      if (start) begin
        k_q <= cfg_k_i;
        acc_cnt <= '0;
        iss_cnt <= '0;
        drn_cnt <= '0;
      end else begin
        acc_cnt <= acc_cnt + WIDTH_K'(push);
        iss_cnt <= iss_cnt + WIDTH_K'(pop);
        drn_cnt <= drn_cnt + DW'(beat);
      end
    end
endmodule

// File: tb/tb_pa_tile_sched.sv
// tb_pa_tile_sched: table vectors, directed corner sequences and random tiles against a queue-based model
module tb_pa_tile_sched;
  import pa_pkg::*;
  localparam int DB = 128;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid_i = 1'b0;
  logic [7:0] cfg_k_i = '0;
  logic cfg_ready_o;
  logic op_valid_i = 1'b0;
  pa_vec_t op_v_i = '0;
  pa_vec_t op_h_i = '0;
  logic op_ready_o;
  pa_vec_t pa_v_bus_o, pa_h_bus_o;
  logic pa_data_rdy_o;
  logic pa_read_en_i = 1'b0;
  logic pa_out_valid_i = 1'b0;
  logic busy_o, done_o, err_o;
  always #5 clk = ~clk;
  pa_tile_sched dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid_i(cfg_valid_i),
    .cfg_k_i(cfg_k_i),
    .cfg_ready_o(cfg_ready_o),
    .op_valid_i(op_valid_i),
    .op_v_i(op_v_i),
    .op_h_i(op_h_i),
    .op_ready_o(op_ready_o),
    .pa_v_bus_o(pa_v_bus_o),
    .pa_h_bus_o(pa_h_bus_o),
    .pa_data_rdy_o(pa_data_rdy_o),
    .pa_read_en_i(pa_read_en_i),
    .pa_out_valid_i(pa_out_valid_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );
  int n_vec = 0;
  int n_bad = 0;
  int ph, mk, macc, miss, mdrn;
  logic merr;
  logic [511:0] mq[$];
  typedef struct {
    logic cv;
    logic [7:0] k;
    logic ov, re, outv;
    logic [7:0] d;
    logic e_cr, e_busy, e_opr, e_rdy, e_err, cb;
    logic [7:0] eh;
  } vec_t;
  vec_t tbl[11];
  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic chkv(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic pa_vec_t rnd_vec();
    pa_vec_t v;
    for (int i = 0; i < $bits(pa_vec_t) / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic model_reset();
    ph = 0;
    mk = 0;
    macc = 0;
    miss = 0;
    mdrn = 0;
    merr = 1'b0;
    mq.delete();
  endtask
  task automatic cyc();
    logic e_opr, e_rdy, push, pop;
    @(negedge clk);
    e_opr = ph == 1 && mq.size() < 2 && macc < mk;
    e_rdy = ph == 1 && mq.size() > 0;
    chk1("cfg_ready", cfg_ready_o, ph == 0);
    chk1("busy", busy_o, ph != 0);
    chk1("done", done_o, ph == 3);
    chk1("err", err_o, merr);
    chk1("op_ready", op_ready_o, e_opr);
    chk1("data_rdy", pa_data_rdy_o, e_rdy);
    if (e_rdy) chkv("bus", {pa_v_bus_o, pa_h_bus_o}, mq[0]);
    push = op_valid_i && e_opr;
    pop = pa_read_en_i && e_rdy;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      merr = (ph == 0 && cfg_valid_i && cfg_k_i == 0) || (pa_out_valid_i && ph != 2);
      if (pop) begin
        void'(mq.pop_front());
        miss++;
      end
      if (push) begin
        mq.push_back({op_v_i, op_h_i});
        macc++;
      end
      case (ph)
        0: if (cfg_valid_i && cfg_k_i != 0) begin
          ph = 1;
          mk = cfg_k_i;
          macc = 0;
          miss = 0;
          mdrn = 0;
        end
        1: if (miss == mk) ph = 2;
        2: if (pa_out_valid_i) begin
          mdrn++;
          if (mdrn == DB) ph = 3;
        end
        default: ph = 0;
      endcase
    end
    #1;
  endtask
  task automatic drive(input logic cv, input logic [7:0] k, input logic ov, input logic re, input logic outv);
    cfg_valid_i = cv;
    cfg_k_i = k;
    op_valid_i = ov;
    pa_read_en_i = re;
    pa_out_valid_i = outv;
    op_v_i = rnd_vec();
    op_h_i = rnd_vec();
    cyc();
  endtask
  task automatic run_drain(input int n);
    repeat (n) drive(0, 0, 0, 0, 1);
  endtask
  task automatic to_drain(input int k);
    int n = 0;
    drive(1, 8'(k), 0, 0, 0);
    while (ph == 1 && n < 100) begin
      drive(0, 0, 1, 1, 0);
      n++;
    end
    chk1("reach_drain", busy_o && !pa_data_rdy_o && !cfg_ready_o, 1'b1);
  endtask
  task automatic run_tile(input int k);
    to_drain(k);
    run_drain(DB);
    chk1("tile_done", done_o, 1'b1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [511:0] first;
    int n_rdy;
    int n;
    tbl[0]  = '{0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[1]  = '{1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[2]  = '{0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00};
    tbl[3]  = '{0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[4]  = '{1, 2, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[5]  = '{0, 0, 1, 0, 0, 8'hA1, 0, 1, 1, 0, 0, 0, 8'h00};
    tbl[6]  = '{0, 0, 1, 0, 1, 8'hB2, 0, 1, 1, 1, 0, 1, 8'hA1};
    tbl[7]  = '{0, 0, 1, 0, 0, 8'hC3, 0, 1, 0, 1, 1, 1, 8'hA1};
    tbl[8]  = '{0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 8'hA1};
    tbl[9]  = '{1, 5, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 8'hB2};
    tbl[10] = '{0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chkv("reset_bus", {pa_v_bus_o, pa_h_bus_o}, '0);
    chk1("reset_done", done_o, 1'b0);
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      cfg_valid_i = tbl[i].cv;
      cfg_k_i = tbl[i].k;
      op_valid_i = tbl[i].ov;
      pa_read_en_i = tbl[i].re;
      pa_out_valid_i = tbl[i].outv;
      op_v_i = {32{tbl[i].d}};
      op_h_i = ~{32{tbl[i].d}};
      @(negedge clk);
      chk1($sformatf("tbl%0d_cfg_ready", i), cfg_ready_o, tbl[i].e_cr);
      chk1($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
      chk1($sformatf("tbl%0d_op_ready", i), op_ready_o, tbl[i].e_opr);
      chk1($sformatf("tbl%0d_data_rdy", i), pa_data_rdy_o, tbl[i].e_rdy);
      chk1($sformatf("tbl%0d_err", i), err_o, tbl[i].e_err);
      chk1($sformatf("tbl%0d_done", i), done_o, 1'b0);
      if (tbl[i].cb) chkv($sformatf("tbl%0d_bus", i), {pa_v_bus_o, pa_h_bus_o}, {{32{tbl[i].eh}}, ~{32{tbl[i].eh}}});
      @(posedge clk);
      #1;
    end
    cfg_valid_i = 1'b0;
    pa_read_en_i = 1'b0;
    for (int i = 0; i < DB; i++) begin
      pa_out_valid_i = 1'b1;
      @(negedge clk);
      if (i == DB - 1) chk1("drain_last_done", done_o, 1'b0);
      @(posedge clk);
      #1;
    end
    pa_out_valid_i = 1'b0;
    @(negedge clk);
    chk1("drain_done", done_o, 1'b1);
    chk1("drain_done_cfg_ready", cfg_ready_o, 1'b0);
    @(negedge clk);
    chk1("after_done", done_o, 1'b0);
    chk1("after_done_cfg_ready", cfg_ready_o, 1'b1);
    chk1("after_done_busy", busy_o, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    run_tile(3);
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    first = {op_v_i, op_h_i};
    repeat (4) drive(0, 0, 1, 0, 0);
    chkv("bp_head", {pa_v_bus_o, pa_h_bus_o}, first);
    chk1("bp_op_ready", op_ready_o, 1'b0);
    n = 0;
    while (ph == 1 && n < 40) begin
      drive(0, 0, 1, 1, 0);
      n++;
    end
    run_drain(DB);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 8, 0, 0, 0);
    n_rdy = 0;
    repeat (12) begin
      drive(0, 0, 1, 1, 0);
      n_rdy += int'(pa_data_rdy_o);
    end
    chk1("simul_issue_cycles", n_rdy == 8, 1'b1);
    run_drain(DB);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    to_drain(1);
    run_drain(50);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b1;
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_idle", cfg_ready_o, 1'b1);
    chk1("rst_err", err_o, 1'b0);
    drive(0, 0, 0, 0, 0);
    run_tile(1);
    for (int c = 0; c < 5000; c++) begin
      rst_n = ($urandom % 1500) != 0;
      drive($urandom_range(0, 3) == 0, 8'($urandom_range(0, 6)), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 6, ph == 2 ? $urandom_range(0, 9) < 9 : $urandom_range(0, 49) == 0);
    end
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
